// File: rtl/touch_sense_pkg.sv
// touch_sense_pkg: register map, identity constants and debounce FSM states for the touch sensor core
package touch_sense_pkg;
    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_NAME1   = 8'h01;
    localparam logic [7:0] ADDR_VERSION = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h08;
    localparam logic [7:0] ADDR_STATUS  = 8'h09;
    localparam logic [7:0] ADDR_COUNT   = 8'h0a;
    localparam logic [31:0] NAME0 = 32'h74736e73;
    localparam logic [31:0] NAME1 = 32'h302e3130;
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } deb_state_t;
endpackage

// File: rtl/touch_debounce.sv
// touch_debounce: two-flop synchroniser plus debounce FSM producing a clean level and a press pulse
module touch_debounce
    import touch_sense_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4800
) (
    input  logic clk,
    input  logic reset,
    input  logic touch_in,
    output logic level,
    output logic press_pulse
);
    logic       sync_d;
    logic       sync_q;
    logic [15:0] cnt;
    deb_state_t state;
    logic       done;
    assign done = cnt == DEBOUNCE_CYCLES - 16'd1;
    // High in the cycle whose clock edge moves the FSM into PRESSED
    assign press_pulse = state == DEB_PRESS && sync_q && done;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d <= 1'b0;
            sync_q <= 1'b0;
            cnt    <= '0;
            state  <= IDLE;
            level  <= 1'b0;
        end else begin
            sync_d <= touch_in;
            sync_q <= sync_d;
            case (state)
                IDLE: if (sync_q) begin
                    state <= DEB_PRESS;
                    cnt   <= '0;
                end
                DEB_PRESS: if (!sync_q) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (done) begin
                    state <= PRESSED;
                    level <= 1'b1;
                    cnt   <= '0;
                end else cnt <= cnt + 16'd1;
                PRESSED: if (!sync_q) begin
                    state <= DEB_RELEASE;
                    cnt   <= '0;
                end
                DEB_RELEASE: if (sync_q) begin
                    state <= PRESSED;
                    cnt   <= '0;
                end else if (done) begin
                    state <= IDLE;
                    level <= 1'b0;
                    cnt   <= '0;
                end else cnt <= cnt + 16'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/touch_sense.sv
// touch_sense: memory-mapped touch sensor core with event latch, press counter and control register
module touch_sense
    import touch_sense_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd4800,
    parameter logic [31:0] CORE_VERSION    = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        touch_in,
    output logic        touch_event,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready
);
    logic        level;
    logic        press_pulse;
    logic        enable;
    logic        status_event;
    logic [15:0] count;
    logic [31:0] reg_val;
    logic        wr;
    logic        press;
    logic        unused_ok;
    assign unused_ok = ^write_data[31:16];
    assign wr = cs && we;
    assign press = press_pulse && enable;
    assign touch_event = status_event;
    touch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .touch_in   (touch_in),
        .level      (level),
        .press_pulse(press_pulse)
    );
    always_comb begin
        reg_val = address == ADDR_NAME0   ? NAME0 :
                  address == ADDR_NAME1   ? NAME1 :
                  address == ADDR_VERSION ? CORE_VERSION :
                  address == ADDR_CTRL    ? {31'd0, enable} :
                  address == ADDR_STATUS  ? {30'd0, level, status_event} :
                  address == ADDR_COUNT   ? {16'd0, count} : 32'd0;
    end
    // A press landing on a STATUS write still sets the event; a COUNT write overrides the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data    <= '0;
            ready        <= 1'b0;
            enable       <= 1'b1;
            status_event <= 1'b0;
            count        <= '0;
        end else begin
            ready        <= cs;
            read_data    <= (cs && !we) ? reg_val : 32'd0;
            enable       <= (wr && address == ADDR_CTRL) ? write_data[0] : enable;
            status_event <= press ? 1'b1 : (wr && address == ADDR_STATUS) ? 1'b0 : status_event;
            count        <= (wr && address == ADDR_COUNT) ? write_data[15:0] :
                            (press && count != 16'hffff) ? count + 16'd1 : count;
        end
    end
endmodule

// File: tb/tb_touch_sense.sv
// tb_touch_sense: directed table-driven and sequence checks of the touch sensor core
module tb_touch_sense;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        touch_in = 1'b0;
    logic        touch_event;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } rd_vec_t;
    rd_vec_t vecs [7];
    touch_sense #(.DEBOUNCE_CYCLES(16'd8), .CORE_VERSION(32'h00000001)) dut (
        .clk        (clk),
        .reset      (reset),
        .touch_in   (touch_in),
        .touch_event(touch_event),
        .cs         (cs),
        .we         (we),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic bus_read(input string name, input logic [7:0] a, input logic [31:0] exp);
        cs = 1'b1;
        we = 1'b0;
        address = a;
        tick(1);
        check({name, " ready"}, {31'd0, ready}, 32'd1);
        check(name, read_data, exp);
        tick(1);
        cs = 1'b0;
        tick(1);
    endtask
    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1;
        we = 1'b1;
        address = a;
        write_data = d;
        tick(2);
        cs = 1'b0;
        we = 1'b0;
        tick(1);
    endtask
    task automatic press_release();
        touch_in = 1'b1;
        tick(20);
        touch_in = 1'b0;
        tick(20);
    endtask
    initial begin
        vecs[0] = '{8'h00, 32'h74736e73};
        vecs[1] = '{8'h01, 32'h302e3130};
        vecs[2] = '{8'h02, 32'h00000001};
        vecs[3] = '{8'h05, 32'h00000000};
        vecs[4] = '{8'h08, 32'h00000001};
        vecs[5] = '{8'h09, 32'h00000000};
        vecs[6] = '{8'h0a, 32'h00000000};
        tick(3);
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset read_data", read_data, 32'd0);
        check("reset touch_event", {31'd0, touch_event}, 32'd0);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 7; i++) bus_read($sformatf("reg 0x%02h", vecs[i].addr), vecs[i].addr, vecs[i].exp);
        // Event lands on the 11th edge after touch_in rises: 2 sync, 1 entry, 8 count
        touch_in = 1'b1;
        tick(10);
        check("event not yet", {31'd0, touch_event}, 32'd0);
        tick(1);
        check("event on time", {31'd0, touch_event}, 32'd1);
        tick(9);
        bus_read("status pressed", 8'h09, 32'h3);
        bus_read("count first", 8'h0a, 32'h1);
        bus_write(8'h09, 32'h0);
        bus_read("status after clear", 8'h09, 32'h2);
        check("touch_event cleared", {31'd0, touch_event}, 32'd0);
        touch_in = 1'b0;
        tick(20);
        bus_read("status released", 8'h09, 32'h0);
        touch_in = 1'b1;
        tick(5);
        touch_in = 1'b0;
        tick(20);
        bus_read("status glitch", 8'h09, 32'h0);
        bus_read("count glitch", 8'h0a, 32'h1);
        touch_in = 1'b1;
        tick(20);
        bus_write(8'h09, 32'h0);
        touch_in = 1'b0;
        tick(3);
        touch_in = 1'b1;
        tick(20);
        bus_read("status bounce", 8'h09, 32'h2);
        bus_read("count bounce", 8'h0a, 32'h2);
        touch_in = 1'b0;
        tick(20);
        bus_write(8'h08, 32'h0);
        bus_read("ctrl off", 8'h08, 32'h0);
        touch_in = 1'b1;
        tick(20);
        bus_read("status disabled", 8'h09, 32'h2);
        bus_read("count disabled", 8'h0a, 32'h2);
        touch_in = 1'b0;
        tick(20);
        bus_write(8'h08, 32'h1);
        press_release();
        bus_read("count reenabled", 8'h0a, 32'h3);
        bus_write(8'h0a, 32'habcdfffe);
        bus_read("count loaded", 8'h0a, 32'hfffe);
        for (int i = 0; i < 3; i++) press_release();
        bus_read("count saturated", 8'h0a, 32'hffff);
        bus_write(8'h09, 32'h0);
        touch_in = 1'b1;
        tick(10);
        cs = 1'b1;
        we = 1'b1;
        address = 8'h09;
        tick(1);
        cs = 1'b0;
        we = 1'b0;
        check("set beats clear", {31'd0, touch_event}, 32'd1);
        tick(5);
        bus_read("status set wins", 8'h09, 32'h3);
        touch_in = 1'b0;
        tick(20);
        bus_write(8'h0a, 32'h5);
        bus_write(8'h08, 32'h0);
        bus_write(8'h08, 32'h1);
        touch_in = 1'b1;
        tick(5);
        cs = 1'b1;
        address = 8'h0a;
        reset = 1'b1;
        touch_in = 1'b0;
        tick(1);
        check("reset mid ready", {31'd0, ready}, 32'd0);
        check("reset mid read_data", read_data, 32'd0);
        reset = 1'b0;
        cs = 1'b0;
        tick(1);
        bus_read("count after reset", 8'h0a, 32'h0);
        bus_read("status after reset", 8'h09, 32'h0);
        bus_read("ctrl after reset", 8'h08, 32'h1);
        tick(20);
        bus_read("status idle after reset", 8'h09, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
